// File: rtl/i2c_master_rw.sv
// ---------------------------------------------------------------------------
// i2c_master_rw
// Single-transaction I2C master: START, 7-bit address + R/W, 0..MAX_BYTES data
// bytes (write or read), STOP. SCL is generated from the system clock, one SCL
// quarter-period lasting CLK_DIV clocks. Every slave ACK slot is checked. When
// reading, the master ACKs every byte except the last, which it NACKs.
//
// Ports
//   i_clock, i_reset       system clock, asynchronous active-high reset
//   i_start                request a transaction (sampled only while idle)
//   i_slave_address, i_rw  target address and direction (latched on accept)
//   i_num_bytes            data byte count, clamped to MAX_BYTES
//   i_wr_data, o_wr_ready  write byte handshake (byte sampled while ready = 1)
//   o_rd_data, o_rd_valid  received byte and its one-cycle strobe
//   i_sda_in, o_sda_oe     SDA pad input / pull-low enable
//   o_scl_out              SCL level
//   o_busy, o_done, o_nack transaction status
// ---------------------------------------------------------------------------
module i2c_master_rw #(
    parameter int unsigned CLK_DIV   = 250,
    parameter int unsigned MAX_BYTES = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [6:0]       i_slave_address,
    input  logic             i_rw,
    input  logic [CNT_W-1:0] i_num_bytes,
    input  logic [7:0]       i_wr_data,
    output logic             o_wr_ready,
    output logic [7:0]       o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_sda_in,
    output logic             o_sda_oe,
    output logic             o_scl_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_nack
);

    localparam int unsigned      CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]    CntLast = CW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] NbMax   = CNT_W'(MAX_BYTES);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StWdata,
        StWack,
        StRdata,
        StRack,
        StStop,
        StDone
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_qtr;
    logic [2:0]       r_bit;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;
    logic             r_rw;
    logic [CNT_W-1:0] r_left;
    logic [1:0]       r_sda_s;
    logic             r_rd_pend;
    logic             r_scl;
    logic             r_sda_oe;
    logic             r_busy;
    logic             r_done;
    logic             r_nack;
    logic             r_wr_ready;
    logic             r_rd_valid;
    logic [7:0]       r_rd_data;

    logic             w_tick;
    logic             w_sample;
    logic             w_qtr0_first;
    logic [CNT_W-1:0] w_nb_clamped;

    assign w_tick       = (r_cnt == CntLast);
    // r_sda_s[1] lags the pad by two clocks, so at the first cycle of Q3 it
    // still reflects SDA during Q2 (CLK_DIV >= 2), well inside SCL high.
    assign w_sample     = (r_qtr == 2'd3) && (r_cnt == '0);
    assign w_qtr0_first = (r_qtr == 2'd0) && (r_cnt == '0);
    assign w_nb_clamped = (i_num_bytes > NbMax) ? NbMax : i_num_bytes;

    assign o_wr_ready = r_wr_ready;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_sda_oe   = r_sda_oe;
    assign o_scl_out  = r_scl;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_nack     = r_nack;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_qtr      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rw       <= 1'b0;
            r_left     <= '0;
            r_sda_s    <= 2'b11;
            r_rd_pend  <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_sda_s    <= {r_sda_s[0], i_sda_in};

            if (r_state == StIdle || r_state == StDone || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Received byte is published one cycle after its bit-0 sample.
            if (r_rd_pend) begin
                r_rd_pend  <= 1'b0;
                r_rd_data  <= r_rx;
                r_rd_valid <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    r_scl    <= 1'b1;
                    r_sda_oe <= 1'b0;
                    if (i_start) begin
                        r_tx     <= {i_slave_address, i_rw};
                        r_rw     <= i_rw;
                        r_left   <= w_nb_clamped;
                        r_nack   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_qtr    <= 2'd0;
                        r_state  <= StStart;
                        // START Q0: SDA falls while SCL stays high
                        r_sda_oe <= 1'b1;
                    end
                end

                StStart: begin
                    if (w_tick) begin
                        if (r_qtr == 2'd0) begin
                            r_qtr <= 2'd1;
                            r_scl <= 1'b0;
                        end else begin
                            r_state  <= StAddr;
                            r_qtr    <= 2'd0;
                            r_bit    <= 3'd7;
                            r_sda_oe <= ~r_tx[7];
                        end
                    end
                end

                StAddr, StAddrAck, StWdata, StWack, StRdata, StRack: begin
                    if (w_sample) begin
                        if (r_state == StRdata) begin
                            r_rx <= {r_rx[6:0], r_sda_s[1]};
                            if (r_bit == 3'd0) begin
                                r_rd_pend <= 1'b1;
                            end
                        end else if ((r_state == StAddrAck || r_state == StWack) && r_sda_s[1]) begin
                            r_nack <= 1'b1;
                        end
                    end

                    // The write byte only arrives with the wr_ready cycle, so the
                    // MSB goes out one clock into Q0 (SCL is still low).
                    if (r_state == StWdata && w_qtr0_first && r_bit == 3'd7) begin
                        r_tx     <= i_wr_data;
                        r_sda_oe <= ~i_wr_data[7];
                    end

                    if (w_tick) begin
                        if (r_qtr != 2'd3) begin
                            r_qtr <= r_qtr + 2'd1;
                            r_scl <= (r_qtr != 2'd0);
                        end else begin
                            r_qtr <= 2'd0;
                            r_scl <= 1'b0;
                            case (r_state)
                                StAddr, StWdata: begin
                                    if (r_bit == 3'd0) begin
                                        r_state  <= (r_state == StAddr) ? StAddrAck : StWack;
                                        r_sda_oe <= 1'b0;
                                    end else begin
                                        r_bit    <= r_bit - 3'd1;
                                        r_sda_oe <= ~r_tx[r_bit - 3'd1];
                                    end
                                end
                                StAddrAck: begin
                                    if (r_nack || r_left == '0) begin
                                        r_state  <= StStop;
                                        r_sda_oe <= 1'b1;
                                    end else begin
                                        r_bit    <= 3'd7;
                                        r_sda_oe <= 1'b0;
                                        if (r_rw) begin
                                            r_state <= StRdata;
                                        end else begin
                                            r_state    <= StWdata;
                                            r_wr_ready <= 1'b1;
                                        end
                                    end
                                end
                                StWack: begin
                                    r_left <= r_left - CNT_W'(1);
                                    if (r_nack || r_left == CNT_W'(1)) begin
                                        r_state  <= StStop;
                                        r_sda_oe <= 1'b1;
                                    end else begin
                                        r_state    <= StWdata;
                                        r_bit      <= 3'd7;
                                        r_wr_ready <= 1'b1;
                                    end
                                end
                                StRdata: begin
                                    if (r_bit == 3'd0) begin
                                        r_state  <= StRack;
                                        // ACK all but the final byte
                                        r_sda_oe <= (r_left != CNT_W'(1));
                                    end else begin
                                        r_bit    <= r_bit - 3'd1;
                                        r_sda_oe <= 1'b0;
                                    end
                                end
                                StRack: begin
                                    r_left <= r_left - CNT_W'(1);
                                    if (r_left == CNT_W'(1)) begin
                                        r_state  <= StStop;
                                        r_sda_oe <= 1'b1;
                                    end else begin
                                        r_state  <= StRdata;
                                        r_bit    <= 3'd7;
                                        r_sda_oe <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                StStop: begin
                    if (w_tick) begin
                        if (r_qtr == 2'd0) begin
                            r_qtr <= 2'd1;
                            r_scl <= 1'b1;
                        end else if (r_qtr == 2'd1) begin
                            r_qtr    <= 2'd2;
                            r_sda_oe <= 1'b0;
                        end else begin
                            r_state <= StDone;
                        end
                    end
                end

                StDone: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end

                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
